// File: rtl/rt_mem_port_responder_pkg.sv
// Shared types and sizing for the RT-core memory port responder.
package rt_mem_pkg;

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned DATA_W    = 128;
  localparam int unsigned DEPTH     = 1024;
  localparam int unsigned AW        = 10;
  localparam int unsigned PORT_W    = $clog2(NUM_PORTS);

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } t_op;

  typedef struct packed {
    t_op                op;
    logic [AW-1:0]      idx;
    logic [DATA_W-1:0]  wdata;
    logic [PORT_W-1:0]  port;
  } t_mem_req;

endpackage

// File: rtl/rt_mem_port_responder_if.sv
// RT-side memory port bundle: per-port request/response lanes plus a busy flag.
interface rt_mem_port_responder_if;
  import rt_mem_pkg::*;

  logic [NUM_PORTS-1:0]             re;
  logic [NUM_PORTS-1:0]             we;
  logic [NUM_PORTS-1:0][31:0]       addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wdata;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata;
  logic [NUM_PORTS-1:0]             rdy;
  logic                             busy;

  modport master (
    output re, we, addr, wdata,
    input  rdata, rdy, busy
  );

  modport slave (
    input  re, we, addr, wdata,
    output rdata, rdy, busy
  );

endinterface

// File: rtl/rt_mem_port_responder_arb.sv
// Combinational round-robin picker: first eligible requester at or above ptr_i, with wrap.
module rt_rr_arbiter
  import rt_mem_pkg::*;
#(
  parameter int unsigned N  = NUM_PORTS,
  parameter int unsigned IW = PORT_W
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  int unsigned   cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand     = (32'(ptr_i) + k) % N;
      cand_idx = IW'(cand);
      if (!gnt_vld_o && elig_i[cand_idx]) begin
        gnt_vld_o           = 1'b1;
        gnt_idx_o           = cand_idx;
        gnt_oh_o[cand_idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rt_mem_port_responder.sv
// Three-stage responder (arbitrate / access / respond) serving NUM_PORTS RT ports
// against one single-ported word store.
module rt_mem_port_responder
  import rt_mem_pkg::*;
#(
  parameter int unsigned NUM_PORTS = rt_mem_pkg::NUM_PORTS,
  parameter int unsigned DATA_W    = rt_mem_pkg::DATA_W,
  parameter int unsigned DEPTH     = rt_mem_pkg::DEPTH,
  parameter int unsigned AW        = rt_mem_pkg::AW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  rt_mem_port_responder_if.slave  bus
);

  logic [NUM_PORTS-1:0]             pend_q, pend_d;
  logic [NUM_PORTS-1:0]             elig;
  logic [NUM_PORTS-1:0]             gnt_oh;
  logic [PORT_W-1:0]                gnt_idx;
  logic                             gnt_vld;
  logic [PORT_W-1:0]                rr_q, rr_d;

  logic                             s1_vld_q;
  t_mem_req                         s1_q, s1_d;

  logic                             s2_vld_q;
  t_op                              s2_op_q;
  logic [PORT_W-1:0]                s2_port_q;
  logic [DATA_W-1:0]                rd_word_q;

  logic [NUM_PORTS-1:0]             rdy_q, rdy_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0]                store [DEPTH];

  logic                             unused_addr;
  assign unused_addr = ^bus.addr;

  // A port whose rdy is high this cycle is already free to re-arm, while pend
  // stays set until the edge so busy does not dip for a held request.
  assign elig = (bus.re | bus.we) & ~(pend_q & ~rdy_q);

  rt_rr_arbiter #(
    .N  (NUM_PORTS),
    .IW (PORT_W)
  ) u_arb (
    .elig_i    (elig),
    .ptr_i     (rr_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  always_comb begin
    s1_d.op    = bus.we[gnt_idx] ? OP_WR : OP_RD;
    s1_d.idx   = bus.addr[gnt_idx][AW+3:4];
    s1_d.wdata = bus.wdata[gnt_idx];
    s1_d.port  = gnt_idx;

    rr_d = rr_q;
    if (gnt_vld) begin
      rr_d = (gnt_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
    end

    pend_d = (pend_q & ~rdy_q) | gnt_oh;

    rdy_d   = '0;
    rdata_d = rdata_q;
    if (s2_vld_q) begin
      rdy_d[s2_port_q] = 1'b1;
      if (s2_op_q == OP_RD) begin
        rdata_d[s2_port_q] = rd_word_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= '0;
      rr_q      <= '0;
      s1_vld_q  <= 1'b0;
      s1_q      <= '0;
      s2_vld_q  <= 1'b0;
      s2_op_q   <= OP_RD;
      s2_port_q <= '0;
      rdy_q     <= '0;
      rdata_q   <= '0;
    end else begin
      pend_q    <= pend_d;
      rr_q      <= rr_d;
      s1_vld_q  <= gnt_vld;
      if (gnt_vld) begin
        s1_q <= s1_d;
      end
      s2_vld_q  <= s1_vld_q;
      s2_op_q   <= s1_q.op;
      s2_port_q <= s1_q.port;
      rdy_q     <= rdy_d;
      rdata_q   <= rdata_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (s1_vld_q) begin
      if (s1_q.op == OP_WR) begin
        store[s1_q.idx] <= s1_q.wdata;
      end else begin
        rd_word_q <= store[s1_q.idx];
      end
    end
  end

  assign bus.rdy   = rdy_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = |pend_q;

endmodule

// File: tb/tb_rt_mem_port_responder.sv
// Directed bench for rt_mem_port_responder with hand-computed expectations.
module tb_rt_mem_port_responder;
  import rt_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [127:0] D0 = 128'hDEADBEEF_CAFEF00D_12345678_9ABC0001;

  rt_mem_port_responder_if bif ();

  rt_mem_port_responder #(
    .NUM_PORTS (4),
    .DATA_W    (128),
    .DEPTH     (1024),
    .AW        (10)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request and wait (bounded) for its rdy; lat is edges from drive to rdy, -1 on timeout.
  task automatic bus_op(input int p, input bit r, input bit w, input logic [31:0] a,
                        input logic [127:0] d, output int lat);
    bif.re[p[1:0]]    = r;
    bif.we[p[1:0]]    = w;
    bif.addr[p[1:0]]  = a;
    bif.wdata[p[1:0]] = d;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (bif.rdy[p[1:0]] === 1'b1) begin
        lat = c;
        break;
      end
    end
    bif.re[p[1:0]] = 1'b0;
    bif.we[p[1:0]] = 1'b0;
  endtask

  task automatic test_reset();
    bif.re = '0; bif.we = '0; bif.addr = '0; bif.wdata = '0;
    rst_n = 1'b0;
    repeat (3) step();
    n_cmp++; if (bif.rdy !== 4'h0) begin n_bad++; $display("FAIL reset_rdy: got %h want 0", bif.rdy); end
    n_cmp++; if (bif.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bif.busy); end
    n_cmp++; if (bif.rdata !== '0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", bif.rdata); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    int lat;
    bus_op(0, 1'b0, 1'b1, 32'h40, D0, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL wr_latency: got %0d want 3", lat); end
    n_cmp++; if (bif.rdata[0] !== 128'h0) begin n_bad++; $display("FAIL wr_rdata_kept: got %h want 0", bif.rdata[0]); end
    bus_op(0, 1'b1, 1'b0, 32'h40, '0, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd_latency: got %0d want 3", lat); end
    n_cmp++; if (bif.rdata[0] !== D0) begin n_bad++; $display("FAIL rd_data: got %h want %h", bif.rdata[0], D0); end
    step();
    n_cmp++; if (bif.rdy !== 4'h0) begin n_bad++; $display("FAIL rdy_one_cycle: got %h want 0", bif.rdy); end
    n_cmp++; if (bif.busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", bif.busy); end
  endtask

  task automatic test_fairness();
    int lat;
    int got;
    int ord [4];
    int cyc [4];
    logic [127:0] val [4];
    for (int i = 0; i < 4; i++) begin
      bus_op(0, 1'b0, 1'b1, 32'(i * 16), 128'(i + 1), lat);
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL preload_lat%0d: got %0d want 3", i, lat); end
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 4; p++) begin
        bif.addr[p[1:0]] = 32'(p * 16);
        bif.re[p[1:0]]   = 1'b1;
      end
      got = 0;
      for (int c = 1; c <= 20 && got < 4; c++) begin
        step();
        n_cmp++; if ($countones(bif.rdy) > 1) begin n_bad++; $display("FAIL fair_onehot: got %h want <=1 bit", bif.rdy); end
        for (int p = 0; p < 4; p++) begin
          if (bif.rdy[p[1:0]] === 1'b1 && got < 4) begin
            ord[got] = p;
            cyc[got] = c;
            val[got] = bif.rdata[p[1:0]];
            got++;
            bif.re[p[1:0]] = 1'b0;
          end
        end
      end
      n_cmp++; if (got !== 4) begin n_bad++; $display("FAIL fair_count r%0d: got %0d want 4", r, got); end
      for (int k = 0; k < got; k++) begin
        n_cmp++; if (ord[k] !== k) begin n_bad++; $display("FAIL fair_order r%0d k%0d: got %0d want %0d", r, k, ord[k], k); end
        n_cmp++; if (cyc[k] !== 3 + k) begin n_bad++; $display("FAIL fair_cycle r%0d k%0d: got %0d want %0d", r, k, cyc[k], 3 + k); end
        n_cmp++; if (val[k] !== 128'(k + 1)) begin n_bad++; $display("FAIL fair_data r%0d k%0d: got %h want %0d", r, k, val[k], k + 1); end
      end
    end
    bif.re = '0;
  endtask

  task automatic test_raw();
    int c1 = -1;
    int c2 = -1;
    logic [127:0] v = '0;
    bif.we[1] = 1'b1; bif.addr[1] = 32'h100; bif.wdata[1] = 128'hA5;
    step();
    bif.re[2] = 1'b1; bif.addr[2] = 32'h100;
    for (int c = 2; c <= 20 && (c1 < 0 || c2 < 0); c++) begin
      step();
      if (bif.rdy[1] === 1'b1) begin c1 = c; bif.we[1] = 1'b0; end
      if (bif.rdy[2] === 1'b1) begin c2 = c; v = bif.rdata[2]; bif.re[2] = 1'b0; end
    end
    bif.we[1] = 1'b0; bif.re[2] = 1'b0;
    n_cmp++; if (c1 !== 3) begin n_bad++; $display("FAIL raw_wr_cycle: got %0d want 3", c1); end
    n_cmp++; if (c2 !== 4) begin n_bad++; $display("FAIL raw_rd_cycle: got %0d want 4", c2); end
    n_cmp++; if (v !== 128'hA5) begin n_bad++; $display("FAIL raw_data: got %h want a5", v); end
  endtask

  task automatic test_conflict_alias();
    int lat;
    bus_op(3, 1'b1, 1'b1, 32'h4010, 128'h77, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL conflict_lat: got %0d want 3", lat); end
    n_cmp++; if (bif.rdata[3] !== 128'h4) begin n_bad++; $display("FAIL conflict_is_write: got %h want 4", bif.rdata[3]); end
    bus_op(0, 1'b1, 1'b0, 32'h10, '0, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL alias_lat: got %0d want 3", lat); end
    n_cmp++; if (bif.rdata[0] !== 128'h77) begin n_bad++; $display("FAIL alias_data: got %h want 77", bif.rdata[0]); end
  endtask

  task automatic test_held();
    logic exp_rdy;
    bif.addr[0] = 32'h30;
    bif.re[0]   = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      exp_rdy = (c % 3 == 0);
      n_cmp++; if (bif.rdy[0] !== exp_rdy) begin n_bad++; $display("FAIL held_rdy c%0d: got %b want %b", c, bif.rdy[0], exp_rdy); end
      n_cmp++; if (bif.busy !== 1'b1) begin n_bad++; $display("FAIL held_busy c%0d: got %b want 1", c, bif.busy); end
    end
    n_cmp++; if (bif.rdata[0] !== 128'h4) begin n_bad++; $display("FAIL held_data: got %h want 4", bif.rdata[0]); end
    bif.re[0] = 1'b0;
    step();
    n_cmp++; if (bif.rdy[0] !== 1'b0) begin n_bad++; $display("FAIL held_stop_rdy: got %b want 0", bif.rdy[0]); end
    n_cmp++; if (bif.busy !== 1'b0) begin n_bad++; $display("FAIL held_stop_busy: got %b want 0", bif.busy); end
  endtask

  task automatic test_reset_mid();
    int lat;
    bif.addr[1] = 32'h20;
    bif.re[1]   = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    bif.re[1] = 1'b0;
    #1;
    n_cmp++; if (bif.rdy !== 4'h0) begin n_bad++; $display("FAIL midrst_rdy: got %h want 0", bif.rdy); end
    n_cmp++; if (bif.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", bif.busy); end
    n_cmp++; if (bif.rdata !== '0) begin n_bad++; $display("FAIL midrst_rdata: got %h want 0", bif.rdata); end
    for (int c = 1; c <= 3; c++) begin
      step();
      n_cmp++; if (bif.rdy !== 4'h0) begin n_bad++; $display("FAIL midrst_hold_rdy c%0d: got %h want 0", c, bif.rdy); end
    end
    rst_n = 1'b1;
    step();
    bus_op(1, 1'b1, 1'b0, 32'h20, '0, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL postrst_lat: got %0d want 3", lat); end
    n_cmp++; if (bif.rdata[1] !== 128'h3) begin n_bad++; $display("FAIL postrst_data: got %h want 3", bif.rdata[1]); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_fairness();
    test_raw();
    test_conflict_alias();
    test_held();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rt_mem_port_responder.md
Name: rt_mem_port_responder

Overview:
- Responder end of the RT-core memory port protocol.
- Serves NUM_PORTS ray-tracing core ports with read and write requests against one single-ported 128-bit word store.
- Arbitration between ports is round-robin; each completed request is answered with a one-cycle rdy pulse.
- Sits between the RT core cluster and on-chip storage; its port bundle matches the RT-side memory interface used by the core top level.

Parameters:
- NUM_PORTS, 4, number of RT request ports.
- DATA_W, 128, word width in bits.
- DEPTH, 1024, words of storage.
- AW, 10, word-index width; must equal log2(DEPTH).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- re  in  NUM_PORTS  per-port read request, level, held until rdy.
- we  in  NUM_PORTS  per-port write request, level, held until rdy.
- addr  in  NUM_PORTS x 32  per-port byte address, 16-byte aligned.
- wdata  in  NUM_PORTS x DATA_W  per-port write data.
- rdata  out  NUM_PORTS x DATA_W  per-port read data, valid with rdy.
- rdy  out  NUM_PORTS  per-port completion pulse, one cycle, for both reads and writes.
- busy  out  1  high while any request is in flight.

Behaviour:
- Reset (async, rst_n low):
  - rdy = 0, rdata = 0, busy = 0.
  - Round-robin pointer = 0, all pending flags cleared.
  - Storage contents are not cleared.
- Addressing:
  - word index = addr[AW+3:4].
  - addr[3:0] and addr[31:AW+4] are ignored; aliasing is by design.
- Request eligibility: port i is eligible when (re[i] | we[i]) and pend[i] == 0.
- Read/write conflict: if re[i] and we[i] are both high, the request is a write; the read is ignored.
- Stage 0 (arbitrate):
  - Grant at most one eligible port per cycle.
  - Search starts at the rr pointer and proceeds upward with wrap.
  - Register the grant index, op, word index and wdata.
  - Set pend[granted] = 1.
  - Pointer becomes granted+1 mod NUM_PORTS; the pointer is unchanged when there is no grant.
- Stage 1 (access):
  - Write: store[idx] <= wdata.
  - Read: read store[idx].
- Stage 2 (respond):
  - Raise rdy[granted] for exactly one cycle.
  - For a read, load rdata[granted] with the read word; for a write, rdata is unchanged.
  - Clear pend[granted] in the same cycle.
- Timing:
  - Latency: request sampled at edge N -> rdy high after edge N+2 (uncontended).
  - Throughput: one grant per cycle across ports. A single port re-arms no earlier than the edge after its rdy, giving 1 per 3 cycles per port.
- Requester rules:
  - Hold re/we/addr/wdata stable until rdy.
  - Deassert or change the request in the cycle rdy is high.
  - If a request is still high after rdy, it is a new request, eligible the following cycle.
- Ordering:
  - Requests are processed in grant order.
  - Read-after-write to the same word, granted in a later cycle, returns the new data.
  - Write-after-read returns the old data.
- rdata[i] holds its last read value until the next read completes for that port.
- busy = OR of pend.
- A request dropped before it is granted is simply never served.
- Reset mid-operation: in-flight ops are discarded with no rdy. A write already in Stage 1 at the reset edge may or may not commit; verification must not depend on it.

Decomposition:
- Package rt_mem_pkg:
  - NUM_PORTS, DATA_W, AW constants.
  - typedef t_op (OP_RD, OP_WR).
  - typedef struct t_mem_req {op, idx[AW-1:0], wdata, port}.
- Sub-module rt_rr_arbiter:
  - Inputs: eligible vector and pointer.
  - Outputs: one-hot grant, grant index, valid.
  - Purely combinational; the pointer register lives in the parent.

Test Plan:
- Basic write then read:
  - we[0], addr 0x00000040, wdata 0xDEADBEEF_..._01 -> rdy[0] pulses 2 cycles later.
  - Then re[0] at 0x40 -> rdy[0] with rdata[0] = written value, latency 2.
- Fairness:
  - All 4 ports assert re at once after reset, at addresses 0x0/0x10/0x20/0x30 preloaded with 1..4.
  - rdy order is port 0,1,2,3 on consecutive cycles; rdata values are 1,2,3,4.
  - Re-assert all -> order 0,1,2,3 again (pointer wrapped to 0).
- RAW across ports:
  - Port 1 writes 0xA5 to 0x100; port 2 reads 0x100 in the next cycle -> rdata[2] = 0xA5.
- Conflict and alias:
  - Port 3 asserts re and we together, wdata 0x77, addr 0x4000+0x10 -> treated as a write.
  - A later read of 0x10 returns 0x77.
- Held request:
  - Port 0 keeps re high for 6 cycles after its first rdy -> rdy[0] pulses every 3 cycles.
  - busy stays high throughout.
- Reset mid-operation:
  - Assert rst_n low one cycle after granting a read -> no rdy, rdata = 0, busy = 0.
  - After release, a new read is served normally.
